// File: rtl/ecsu_pkg.sv
// Shared definitions for the ECSU hazard block: state encoding, default
// thresholds and a helper that sizes the debounce counters.
package ecsu_pkg;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    ADVISORY  = 2'd1,
    SEVERE    = 2'd2,
    EMERGENCY = 2'd3
  } ecsu_state_e;

  localparam int unsigned DEF_WIND_W   = 6;
  localparam int unsigned DEF_TEMP_W   = 8;
  localparam int unsigned DEF_ADV_WIND = 10;
  localparam int unsigned DEF_SEV_WIND = 15;
  localparam int unsigned DEF_EMG_WIND = 20;
  localparam int          DEF_SEV_TEMP = 35;
  localparam int          DEF_EMG_TEMP = 40;
  localparam int unsigned DEF_ESC_CNT  = 2;
  localparam int unsigned DEF_CLR_CNT  = 3;

  // Width able to hold the larger of the two debounce limits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ecsu_hazard_classify.sv
// Combinational hazard classifier: maps one weather sample to a level 0..3.
// Ports: thunderstorm, wind, visibility (3 = worst), signed temperature in;
//        level_c (2-bit hazard level) out.
module ecsu_hazard_classify
  import ecsu_pkg::*;
#(
  parameter int unsigned WIND_W   = DEF_WIND_W,
  parameter int unsigned TEMP_W   = DEF_TEMP_W,
  parameter int unsigned ADV_WIND = DEF_ADV_WIND,
  parameter int unsigned SEV_WIND = DEF_SEV_WIND,
  parameter int unsigned EMG_WIND = DEF_EMG_WIND,
  parameter int          SEV_TEMP = DEF_SEV_TEMP,
  parameter int          EMG_TEMP = DEF_EMG_TEMP
) (
  input  logic              thunderstorm,
  input  logic [WIND_W-1:0] wind,
  input  logic [1:0]        visibility,
  input  logic [TEMP_W-1:0] temperature,
  output logic [1:0]        level_c
);

  localparam logic [WIND_W-1:0] ADV_W_L = WIND_W'(ADV_WIND);
  localparam logic [WIND_W-1:0] SEV_W_L = WIND_W'(SEV_WIND);
  localparam logic [WIND_W-1:0] EMG_W_L = WIND_W'(EMG_WIND);

  // Signed limits; comparing both directions avoids abs() overflow at the most negative value.
  localparam logic signed [TEMP_W-1:0] SEV_HI = TEMP_W'(SEV_TEMP);
  localparam logic signed [TEMP_W-1:0] SEV_LO = TEMP_W'(-SEV_TEMP);
  localparam logic signed [TEMP_W-1:0] EMG_HI = TEMP_W'(EMG_TEMP);
  localparam logic signed [TEMP_W-1:0] EMG_LO = TEMP_W'(-EMG_TEMP);

  logic signed [TEMP_W-1:0] temp_s;
  logic emg_c, sev_c, adv_c;

  assign temp_s = $signed(temperature);

  assign emg_c = (temp_s > EMG_HI) || (temp_s < EMG_LO) || (wind > EMG_W_L);
  assign sev_c = thunderstorm || (temp_s > SEV_HI) || (temp_s < SEV_LO) ||
                 (wind > SEV_W_L) || (visibility == 2'd3);
  assign adv_c = (wind > ADV_W_L) || (visibility != 2'd0);

  // Highest matching level wins.
  always_comb begin
    level_c = 2'd0;
    if (emg_c)      level_c = 2'd3;
    else if (sev_c) level_c = 2'd2;
    else if (adv_c) level_c = 2'd1;
  end

endmodule

// File: rtl/ecsu_hazard_fsm.sv
// ECSU hazard state machine with escalation/clear debounce and sticky emergency.
// Ports: CLK, RST (sync, active-high), sample_valid, thunderstorm, wind,
//        visibility, temperature, alert_ack in; severe_weather,
//        emergency_landing_alert, ECSU_state, state_change out (all registered).
module ecsu_hazard_fsm
  import ecsu_pkg::*;
#(
  parameter int unsigned WIND_W   = DEF_WIND_W,
  parameter int unsigned TEMP_W   = DEF_TEMP_W,
  parameter int unsigned ADV_WIND = DEF_ADV_WIND,
  parameter int unsigned SEV_WIND = DEF_SEV_WIND,
  parameter int unsigned EMG_WIND = DEF_EMG_WIND,
  parameter int          SEV_TEMP = DEF_SEV_TEMP,
  parameter int          EMG_TEMP = DEF_EMG_TEMP,
  parameter int unsigned ESC_CNT  = DEF_ESC_CNT,
  parameter int unsigned CLR_CNT  = DEF_CLR_CNT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sample_valid,
  input  logic              thunderstorm,
  input  logic [WIND_W-1:0] wind,
  input  logic [1:0]        visibility,
  input  logic [TEMP_W-1:0] temperature,
  input  logic              alert_ack,
  output logic              severe_weather,
  output logic              emergency_landing_alert,
  output logic [1:0]        ECSU_state,
  output logic              state_change
);

  localparam int unsigned      CNT_W   = cnt_width(ESC_CNT, CLR_CNT);
  localparam logic [CNT_W-1:0] ESC_LIM = CNT_W'(ESC_CNT);
  localparam logic [CNT_W-1:0] CLR_LIM = CNT_W'(CLR_CNT);

  logic [1:0]       level_c;
  ecsu_state_e      state_q, state_n;
  logic [CNT_W-1:0] esc_q, esc_n, clr_q, clr_n;
  logic [CNT_W-1:0] esc_inc_c, clr_inc_c;

  ecsu_hazard_classify #(
    .WIND_W  (WIND_W),
    .TEMP_W  (TEMP_W),
    .ADV_WIND(ADV_WIND),
    .SEV_WIND(SEV_WIND),
    .EMG_WIND(EMG_WIND),
    .SEV_TEMP(SEV_TEMP),
    .EMG_TEMP(EMG_TEMP)
  ) u_classify (
    .thunderstorm(thunderstorm),
    .wind        (wind),
    .visibility  (visibility),
    .temperature (temperature),
    .level_c     (level_c)
  );

  // Saturating increments so the counters can never wrap.
  assign esc_inc_c = (esc_q == '1) ? esc_q : esc_q + CNT_W'(1);
  assign clr_inc_c = (clr_q == '1) ? clr_q : clr_q + CNT_W'(1);

  // Next state and counters for a qualified sample.
  always_comb begin
    state_n = state_q;
    esc_n   = esc_q;
    clr_n   = clr_q;
    if ((level_c == 2'd3) || (state_q == EMERGENCY)) begin
      // Level 3 jumps in immediately; EMERGENCY leaves only on an acknowledged lower sample.
      esc_n = '0;
      clr_n = '0;
      if (level_c == 2'd3)  state_n = EMERGENCY;
      else if (alert_ack)   state_n = SEVERE;
    end else if (level_c > 2'(state_q)) begin
      clr_n = '0;
      esc_n = esc_inc_c;
      if (esc_inc_c >= ESC_LIM) begin
        state_n = ecsu_state_e'(level_c);
        esc_n   = '0;
      end
    end else if (level_c < 2'(state_q)) begin
      esc_n = '0;
      clr_n = clr_inc_c;
      if (clr_inc_c >= CLR_LIM) begin
        state_n = ecsu_state_e'(2'(state_q) - 2'd1);
        clr_n   = '0;
      end
    end else begin
      esc_n = '0;
      clr_n = '0;
    end
  end

  // State, counters and registered outputs; state_change is a single-cycle pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q                 <= CLEAR;
      esc_q                   <= '0;
      clr_q                   <= '0;
      severe_weather          <= 1'b0;
      emergency_landing_alert <= 1'b0;
      state_change            <= 1'b0;
    end else begin
      state_change <= 1'b0;
      if (sample_valid) begin
        state_q                 <= state_n;
        esc_q                   <= esc_n;
        clr_q                   <= clr_n;
        severe_weather          <= (state_n == SEVERE) || (state_n == EMERGENCY);
        emergency_landing_alert <= (state_n == EMERGENCY);
        state_change            <= (state_n != state_q);
      end
    end
  end

  assign ECSU_state = 2'(state_q);

endmodule

// File: tb/tb_ecsu_hazard_fsm.sv
// Scoreboard bench for ecsu_hazard_fsm: a default instance (A) and a
// single-sample-debounce, 8-bit-wind instance (B) share the stimulus.
module tb_ecsu_hazard_fsm;

  typedef struct {
    logic [1:0] st;
    logic       sc;
    int         id;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic       thunderstorm;
  logic [7:0] wind_s;
  logic [1:0] visibility;
  logic [7:0] temperature;
  logic       alert_ack;

  logic       a_sev, a_emg, a_sc;
  logic [1:0] a_st;
  logic       b_sev, b_emg, b_sc;
  logic [1:0] b_st;

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;
  int   step_id = 0;

  ecsu_hazard_fsm dut_a (
    .CLK                    (clk),
    .RST                    (rst),
    .sample_valid           (sample_valid),
    .thunderstorm           (thunderstorm),
    .wind                   (wind_s[5:0]),
    .visibility             (visibility),
    .temperature            (temperature),
    .alert_ack              (alert_ack),
    .severe_weather         (a_sev),
    .emergency_landing_alert(a_emg),
    .ECSU_state             (a_st),
    .state_change           (a_sc)
  );

  ecsu_hazard_fsm #(
    .WIND_W (8),
    .ESC_CNT(1),
    .CLR_CNT(1)
  ) dut_b (
    .CLK                    (clk),
    .RST                    (rst),
    .sample_valid           (sample_valid),
    .thunderstorm           (thunderstorm),
    .wind                   (wind_s),
    .visibility             (visibility),
    .temperature            (temperature),
    .alert_ack              (alert_ack),
    .severe_weather         (b_sev),
    .emergency_landing_alert(b_emg),
    .ECSU_state             (b_st),
    .state_change           (b_sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void cmp(input string name, input int id, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
    end
  endfunction

  // Monitor: every edge that had a stimulus cycle behind it yields one expectation per instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp("A.state",        e.id, int'(a_st),  int'(e.st));
        cmp("A.severe",       e.id, int'(a_sev), int'(e.st >= 2'd2));
        cmp("A.emergency",    e.id, int'(a_emg), int'(e.st == 2'd3));
        cmp("A.state_change", e.id, int'(a_sc),  int'(e.sc));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp("B.state",        e.id, int'(b_st),  int'(e.st));
        cmp("B.severe",       e.id, int'(b_sev), int'(e.st >= 2'd2));
        cmp("B.emergency",    e.id, int'(b_emg), int'(e.st == 2'd3));
        cmp("B.state_change", e.id, int'(b_sc),  int'(e.sc));
      end
    end
  end

  // Drive one cycle on the falling edge and queue the expected post-edge response.
  task automatic smp(input bit b, input bit r, input bit v, input int w, input int vis,
                     input int t, input bit ts, input bit ack, input int es, input bit sc);
    exp_t e;
    @(negedge clk);
    rst          = r;
    sample_valid = v;
    wind_s       = 8'(w);
    visibility   = 2'(vis);
    temperature  = 8'(t);
    thunderstorm = ts;
    alert_ack    = ack;
    step_id++;
    e.st = 2'(es);
    e.sc = sc;
    e.id = step_id;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endtask

  // Shorthands: plain valid sample, idle cycle, reset cycle.
  task automatic ws(input bit b, input int w, input int vis, input int t, input bit ack,
                    input int es, input bit sc);
    smp(b, 1'b0, 1'b1, w, vis, t, 1'b0, ack, es, sc);
  endtask

  task automatic idle(input bit b, input bit ack, input int es);
    smp(b, 1'b0, 1'b0, 0, 0, 0, 1'b0, ack, es, 1'b0);
  endtask

  task automatic rst_cyc(input bit b);
    smp(b, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; thunderstorm = 1'b0; wind_s = '0;
    visibility = '0; temperature = '0; alert_ack = 1'b0;

    rst_cyc(0); rst_cyc(0);

    // Temperature boundaries
    ws(0, 0, 0,   35, 0, 0, 0);
    ws(0, 0, 0,  -35, 0, 0, 0);
    ws(0, 0, 0,   36, 0, 0, 0);
    ws(0, 0, 0,   36, 0, 2, 1);
    rst_cyc(0);
    ws(0, 0, 0,  -36, 0, 0, 0);
    ws(0, 0, 0,  -36, 0, 2, 1);
    rst_cyc(0);
    ws(0, 0, 0, -128, 0, 3, 1);
    ws(0, 0, 0,    0, 0, 3, 0);
    rst_cyc(0);

    // Escalate then clear, with idle gaps holding the counts
    ws(0, 12, 0, 0, 0, 0, 0);
    ws(0, 12, 0, 0, 0, 1, 1);
    idle(0, 0, 1);
    ws(0, 5, 0, 0, 0, 1, 0);
    idle(0, 0, 1);
    idle(0, 0, 1);
    ws(0, 5, 0, 0, 0, 1, 0);
    ws(0, 5, 0, 0, 0, 0, 1);
    idle(0, 0, 0);

    // Debounce break, then direct 0 -> 2
    ws(0, 16, 0, 0, 0, 0, 0);
    ws(0,  8, 0, 0, 0, 0, 0);
    ws(0, 16, 0, 0, 0, 0, 0);
    ws(0, 16, 0, 0, 0, 2, 1);
    ws(0, 16, 0, 0, 0, 2, 0);
    // Wind exactly at the emergency limit is level 2 and breaks the clear run
    ws(0, 12, 0, 0, 0, 2, 0);
    ws(0, 12, 0, 0, 0, 2, 0);
    ws(0, 20, 0, 0, 0, 2, 0);
    ws(0, 12, 0, 0, 0, 2, 0);
    ws(0, 12, 0, 0, 0, 2, 0);
    ws(0, 12, 0, 0, 0, 1, 1);
    ws(0,  0, 1, 0, 0, 1, 0);
    ws(0,  0, 3, 0, 0, 1, 0);
    ws(0,  0, 3, 0, 0, 2, 1);

    // Sticky emergency
    ws(0, 25, 0, 0, 0, 3, 1);
    for (int i = 0; i < 5; i++) ws(0, 0, 0, 0, 0, 3, 0);
    idle(0, 1, 3);
    ws(0,  0, 0, 0, 1, 2, 1);
    ws(0, 25, 0, 0, 1, 3, 1);
    ws(0, 25, 0, 0, 1, 3, 0);
    ws(0,  0, 0, 0, 1, 2, 1);

    // Reset mid-operation with a clear count of 2 pending
    ws(0, 0, 0, 0, 0, 2, 0);
    ws(0, 0, 0, 0, 0, 2, 0);
    smp(0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    ws(0, 12, 0, 0, 0, 0, 0);
    ws(0, 12, 0, 0, 0, 1, 1);

    // Single-sample debounce instance with 8-bit wind
    rst_cyc(1); rst_cyc(1);
    ws(1, 200, 0,  0, 0, 3, 1);
    ws(1,   0, 0,  0, 0, 3, 0);
    ws(1,   0, 0,  0, 1, 2, 1);
    ws(1,   0, 0,  0, 0, 1, 1);
    ws(1,   0, 0,  0, 0, 0, 1);
    ws(1,  12, 0,  0, 0, 1, 1);
    ws(1,  16, 0,  0, 0, 2, 1);
    ws(1,  12, 0,  0, 0, 1, 1);
    ws(1,   0, 0,  0, 0, 0, 1);
    ws(1,   0, 0, 41, 0, 3, 1);

    idle(1, 0, 3);
    @(negedge clk);
    rst = 1'b0; sample_valid = 1'b0;
    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
    if (qa.size() > 0 || qb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", qa.size() + qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecsu_hazard_fsm.md
ECSU_HAZARD_FSM -- requirements
Module: ecsu_hazard_fsm

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- WIND_W 6: wind width.
- TEMP_W 8: signed temperature width.
- ADV_WIND 10: advisory wind limit.
- SEV_WIND 15: severe wind limit.
- EMG_WIND 20: emergency wind limit.
- SEV_TEMP 35: severe |temperature| limit.
- EMG_TEMP 40: emergency |temperature| limit.
- ESC_CNT 2: consecutive samples needed to escalate to level 1/2.
- CLR_CNT 3: consecutive samples needed to de-escalate.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- CLK in 1: clock.
- RST in 1: reset.
- sample_valid in 1: sample qualifier.
- thunderstorm in 1: storm flag.
- wind in WIND_W: wind speed.
- visibility in 2: visibility, 3 = worst.
- temperature in TEMP_W: signed temperature.
- alert_ack in 1: emergency acknowledge.
- severe_weather out 1: state >= 2.
- emergency_landing_alert out 1: state == 3.
- ECSU_state out 2: current state.
- state_change out 1: one-cycle pulse on any state update.
REQ-003 The design SHALL use one clock, CLK; reset RST SHALL be synchronous and active-high.

Function
REQ-004 The classifier SHALL compute a level for each sample as follows:
- 3 if temperature > EMG_TEMP, temperature < -EMG_TEMP, or wind > EMG_WIND.
- else 2 if thunderstorm, temperature > SEV_TEMP, temperature < -SEV_TEMP, wind > SEV_WIND, or visibility == 3.
- else 1 if wind > ADV_WIND or visibility != 0.
- else 0.
REQ-005 Temperature comparisons SHALL be signed against sign-extended constants; no absolute-value computation (-128 must classify as level 3).
REQ-006 State, counters and outputs SHALL change only on cycles with sample_valid=1, except for RST.
REQ-007 States SHALL be CLEAR(0), ADVISORY(1), SEVERE(2) and EMERGENCY(3).
REQ-008 Level 3 escalation: a valid sample with level 3 SHALL enter EMERGENCY on the next edge, with no debounce, from any state.
REQ-009 Level 1/2 escalation: an escalation counter SHALL count consecutive valid samples with level > state; at ESC_CNT the state SHALL become the level of that sample (a direct jump is allowed, e.g. 0->2). Both counters SHALL then clear.
REQ-010 De-escalation: a clear counter SHALL count consecutive valid samples with level < state; at CLR_CNT the state SHALL drop by exactly one and both counters SHALL clear. EMERGENCY is excluded from this rule.
REQ-011 A valid sample with level == state, or a change of direction (up vs down), SHALL clear the counter of the opposite direction and restart the current one at 1 where applicable.
REQ-012 EMERGENCY SHALL be sticky: it SHALL exit to SEVERE only on a valid sample with level < 3 and alert_ack=1 in the same cycle. alert_ack without sample_valid SHALL be ignored.
REQ-013 All outputs SHALL be registered. severe_weather and emergency_landing_alert SHALL be consistent with ECSU_state in the same cycle.
REQ-014 state_change SHALL be high for exactly one cycle, coincident with a new ECSU_state value.
REQ-015 Counters SHALL saturate and never wrap. Their width SHALL be $clog2(max(ESC_CNT, CLR_CNT)+1).

Reset
REQ-016 On RST=1 at a CLK edge, the following SHALL be 0 on the next cycle, regardless of sample_valid or an in-progress count: ECSU_state, severe_weather, emergency_landing_alert, state_change and both counters.
REQ-017 The first valid sample after reset SHALL be evaluated from CLEAR with zero counts.

Structure
REQ-018 Shared package ecsu_pkg SHALL hold the state encodings (CLEAR, ADVISORY, SEVERE, EMERGENCY) and the default threshold constants.
REQ-019 Classification SHALL be a combinational sub-module ecsu_hazard_classify, parameterised with the thresholds and producing the 2-bit level. The FSM and counters SHALL reside in ecsu_hazard_fsm.

Verification
REQ-020 The bench SHALL cover these directed scenarios (default parameters):
- Temperature boundaries: +35 and -35 -> level 0; +36 and -36 -> state 2 after 2 valid samples; -128 -> state 3 after 1 sample.
- Escalate then clear: wind=12 for 2 valid samples -> state 1 with state_change pulse; then wind=5, vis=0 for 3 samples -> state 0; a gap of sample_valid=0 cycles mid-run keeps counts.
- Debounce break: wind=16, wind=8, wind=16 -> stays 0. Then wind=16, wind=16 -> 0->2 directly, severe_weather=1.
- Sticky emergency: wind=25 -> state 3, both alerts 1. Then wind=0 with alert_ack=0 for 5 samples -> stays 3. Then wind=0 with alert_ack=1 -> state 2.
- Reset mid-operation: state 2 with clear count at 2, assert RST with sample_valid=1 -> all outputs 0 next cycle. Then 1 sample of wind=12 -> still state 0.
- Parameter sweep: ESC_CNT=1, CLR_CNT=1, WIND_W=8, wind=200 -> state 3 immediately; each state transition takes a single sample.
